// File: rtl/pipeline_pkg.sv
// Shared defaults for the elastic add-pipeline: data width, stage count and per-stage increment.
package pipeline_pkg;

  localparam int unsigned PIPE_WIDTH     = 32;
  localparam int unsigned PIPE_DEPTH     = 5;
  localparam int unsigned PIPE_STAGE_INC = 10;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus data register that loads src_data + STAGE_INC when enabled.
module pipe_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] STAGE_INC = WIDTH'(PIPE_STAGE_INC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // clear only drops the valid bit; data left behind is don't-care
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      valid_d = src_valid;
      data_d  = src_data + STAGE_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/param_pipeline_unit.sv
// Elastic, bubble-collapsing pipeline of DEPTH add stages with flush and a registered occupancy count.
module param_pipeline_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH,
  parameter int unsigned      DEPTH     = PIPE_DEPTH,
  parameter logic [WIDTH-1:0] STAGE_INC = WIDTH'(PIPE_STAGE_INC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] advance;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             accept;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q, occ_d;

  // A stage may move whenever any slot at or downstream of it is empty or the output drains
  always_comb begin
    advance          = '0;
    advance[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      advance[i] = advance[i+1] | ~v[i];
    end
  end

  assign in_ready  = advance[0] & ~flush & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = d[DEPTH-1];

  always_comb begin
    src_v    = '0;
    src_v[0] = accept;
    src_d[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH    (WIDTH),
      .STAGE_INC(STAGE_INC)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .load_en  (advance[g]),
      .src_valid(src_v[g]),
      .src_data (src_d[g]),
      .valid    (v[g]),
      .data     (d[g])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({accept, out_fire})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_param_pipeline_unit.sv
// Directed and randomised stimulus against a queue-of-beats model of the elastic pipeline.
module tb_param_pipeline_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int INC   = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  occupancy;

  int nvec = 0;
  int nerr = 0;

  param_pipeline_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .STAGE_INC(32'd10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: in-flight beats oldest first, each with its input value and slot position.
  typedef struct {
    logic [31:0] data;
    int          pos;
  } beat_t;

  beat_t mq[$];
  beat_t nq[$];
  beat_t b;
  bit    model_ok = 0;
  bit    m_stall;
  bit    m_acc;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      model_ok = 1;
    end else if (model_ok) begin
      if (flush) begin
        mq.delete();
      end else begin
        m_acc   = in_valid && !(mq.size() == DEPTH && !out_ready);
        m_stall = mq.size() > 0 && mq[0].pos == DEPTH - 1 && !out_ready;
        nq.delete();
        foreach (mq[j]) begin
          b = mq[j];
          if (b.pos == DEPTH - 1) begin
            if (!out_ready) nq.push_back(b);
          end else if (m_stall && b.pos == DEPTH - 1 - j) begin
            nq.push_back(b);
          end else begin
            b.pos++;
            nq.push_back(b);
          end
        end
        if (m_acc) nq.push_back('{data: in_data, pos: 0});
        mq = nq;
      end
    end
  end

  logic        e_valid;
  logic        e_ready;
  logic [31:0] e_data;

  always @(negedge clk) begin
    if (model_ok) begin
      e_valid = mq.size() > 0 && mq[0].pos == DEPTH - 1 && !flush;
      e_ready = !(mq.size() == DEPTH && !out_ready) && !flush && !reset;
      chk("m_out_valid", out_valid, e_valid);
      chk("m_in_ready", in_ready, e_ready);
      chk("m_occupancy", occupancy, mq.size());
      if (e_valid) begin
        e_data = mq[0].data + 32'(DEPTH * INC);
        chk("m_out_data", out_data, e_data);
      end
    end
  end

  task automatic step(input logic rv, input logic [31:0] dat, input logic ordy,
                      input logic fl, input logic rst);
    @(posedge clk);
    #1;
    in_valid  = rv;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
  endtask

  int got, peak, first_s, last_s, acc_n;
  bit seen;

  initial begin
    // reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);

    // single beat latency
    step(1, 32'h5, 1, 0, 0);
    chk("t1_in_ready", in_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 0, 0);
      chk("t1_early_valid", out_valid, 0);
    end
    step(0, 0, 1, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h37);
    step(0, 0, 1, 0, 0);
    chk("t1_occ_empty", occupancy, 0);

    // back-to-back 1..8
    got = 0; peak = 0; first_s = -1; last_s = -1;
    for (int k = 0; k < 20 && got < 8; k++) begin
      if (k < 8) begin
        step(1, 32'(k + 1), 1, 0, 0);
        chk("t2_in_ready", in_ready, 1);
      end else begin
        step(0, 0, 1, 0, 0);
      end
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (out_valid) begin
        chk("t2_data", out_data, 32'(51 + got));
        if (first_s < 0) first_s = k;
        last_s = k;
        got++;
      end
    end
    chk("t2_count", got, 8);
    chk("t2_consecutive", last_s - first_s, 7);
    chk("t2_peak", peak, 5);

    // backpressure fill and drain
    acc_n = 0;
    for (int k = 0; k < 7; k++) begin
      step(1, 32'(100 + k), 0, 0, 0);
      if (in_ready) acc_n++;
    end
    chk("t3_accepts", acc_n, 5);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_full_occ", occupancy, 5);
    chk("t3_held_data", out_data, 32'd150);
    step(0, 0, 0, 0, 0);
    chk("t3_still_held", out_data, 32'd150);
    got = 0;
    for (int k = 0; k < 12 && got < 5; k++) begin
      step(0, 0, 1, 0, 0);
      if (out_valid) begin
        chk("t3_drain", out_data, 32'(150 + got));
        got++;
      end
    end
    chk("t3_drain_count", got, 5);
    step(0, 0, 1, 0, 0);
    chk("t3_occ_empty", occupancy, 0);

    // wrap-around
    step(1, 32'hFFFF_FFF0, 1, 0, 0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(0, 0, 1, 0, 0);
      if (out_valid) begin
        seen = 1;
        chk("t4_wrap", out_data, 32'h22);
      end
    end
    chk("t4_seen", seen, 1);

    // flush with beats in flight
    step(1, 1, 1, 0, 0);
    step(1, 2, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    step(1, 77, 1, 1, 0);
    chk("t5_flush_ready", in_ready, 0);
    chk("t5_flush_valid", out_valid, 0);
    step(0, 0, 1, 0, 0);
    chk("t5_post_occ", occupancy, 0);
    chk("t5_post_valid", out_valid, 0);
    step(1, 200, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 0, 0);
      chk("t5_early_valid", out_valid, 0);
    end
    step(0, 0, 1, 0, 0);
    chk("t5_valid", out_valid, 1);
    chk("t5_data", out_data, 32'd250);

    // reset mid-stream under backpressure
    for (int k = 0; k < 4; k++) step(1, 32'(400 + k), 0, 0, 0);
    step(1, 500, 0, 0, 1);
    chk("t6_rst_ready", in_ready, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_occ", occupancy, 0);
    step(1, 300, 1, 0, 0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(0, 0, 1, 0, 0);
      if (out_valid) begin
        seen = 1;
        chk("t6_resume", out_data, 32'd350);
      end
    end
    chk("t6_seen", seen, 1);

    // mixed traffic checked by the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 79) == 0));
    end
    for (int k = 0; k < 12; k++) step(0, 0, 1, 0, 0);
    chk("end_occ", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/param_pipeline_unit.md
PARAM_PIPELINE_UNIT -- requirements
Module: param_pipeline_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 5, the number of register stages (>=1).
REQ-003 SHALL have parameter STAGE_INC, default 10, the WIDTH-bit constant each stage adds.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port flush  input  1  discard all in-flight data.
REQ-010 SHALL have port out_data  output  WIDTH  result payload.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 SHALL hold a valid bit v[i] and a data register d[i] for each stage i = 0..DEPTH-1, where stage 0 is the input stage and stage DEPTH-1 drives out_data/out_valid.
REQ-015 SHALL compute each stage's next data as the previous data plus STAGE_INC, modulo 2^WIDTH (carry discarded), so a beat exits as in_data + DEPTH*STAGE_INC mod 2^WIDTH.
REQ-016 SHALL define advance[DEPTH-1] = out_ready | ~v[DEPTH-1], and advance[i] = advance[i+1] | ~v[i] for i < DEPTH-1 (elastic, bubble-collapsing).
REQ-017 SHALL drive in_ready = advance[0] & ~flush & ~reset, combinationally.
REQ-018 SHALL accept an input only on in_valid & in_ready; stage 0 then loads in_data + STAGE_INC.
REQ-019 SHALL, when advance[i] is set, load stage i from stage i-1 (stage 0 from the input), and SHALL hold both v[i] and d[i] unchanged when advance[i] is clear.
REQ-020 SHALL have a latency of exactly DEPTH cycles from accept to out_valid when there is no backpressure, and full throughput of 1 beat/cycle.
REQ-021 SHALL drive out_valid = v[DEPTH-1] & ~flush; a beat leaves on out_valid & out_ready.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL deliver beats in acceptance order, with none lost or duplicated outside a flush.
REQ-024 SHALL, on flush=1, clear all v[i] at the next edge, accept no input, complete no output handshake, and leave d[i] don't-care.
REQ-025 SHALL give flush priority over simultaneous in_valid, out_ready or stall.
REQ-026 SHALL keep occupancy as a registered counter: +1 on accept only, -1 on output handshake only, unchanged when both or neither occur, and 0 after flush.
REQ-027 SHALL keep occupancy equal to popcount(v) at all times and never above DEPTH.
REQ-028 SHALL, with DEPTH=1, behave as a single skid-less register slice under the same rules.

Reset
REQ-029 SHALL, with reset=1 at a clock edge, set all v[i]=0, all d[i]=0 and occupancy=0, and therefore out_valid=0 and out_data=0.
REQ-030 SHALL treat a mid-operation reset as a flush plus data clear, accepting no input during the reset cycle (in_ready=0).
REQ-031 SHALL have reset take priority over flush and all handshakes.

Structure
REQ-032 SHALL source the default values of WIDTH, DEPTH and STAGE_INC from the shared package pipeline_pkg.
REQ-033 SHALL implement one sub-module, pipe_stage (valid+data register with add, load enable and clear), instantiated DEPTH times through a generate loop.

Verification (WIDTH=32, DEPTH=5, STAGE_INC=10)
REQ-034 SHALL cover: reset, then one beat in_data=0x00000005 with out_ready=1 -> out_valid=1 exactly 5 cycles after accept, out_data=0x00000037, occupancy then returns to 0.
REQ-035 SHALL cover: back-to-back in_data 1..8 with out_ready=1 -> out_data 51..58 on 8 consecutive cycles, in_ready constantly 1, occupancy peaks at 5.
REQ-036 SHALL cover: continuous input with out_ready=0 -> in_ready=0 after 5 accepts, occupancy=5, out_data held; on out_ready=1, all beats drain in order with no loss.
REQ-037 SHALL cover: in_data=0xFFFFFFF0 -> out_data=0x00000022 (wrap-around).
REQ-038 SHALL cover: flush=1 with 3 beats in flight and in_valid=1 -> in_ready=0 and out_valid=0 that cycle, occupancy=0 and all v=0 next cycle, and the next post-flush beat emerges correctly after 5 cycles.
REQ-039 SHALL cover: reset asserted mid-stream under backpressure -> next cycle out_valid=0, out_data=0, occupancy=0, and normal operation resumes.
